// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified shift controller (LSL/LSR/ASR/ROR).
// Special cases resolve in one cycle; others iterate STEP_MAX bits/cycle.
module shift_sequencer #(
  parameter int STEP_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  shift_type,
  input  logic [31:0] operand,
  input  logic [7:0]  amount,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;
  localparam logic [4:0] SM  = 5'(STEP_MAX);

  state_t      state;
  logic [1:0]  typ;
  logic [31:0] work;
  logic [4:0]  rem;

  logic        fast;
  logic [31:0] f_res;
  logic        f_c;

  logic [4:0]  step;
  logic [31:0] nxt;
  logic        nc;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    fast  = 1'b1;
    f_res = operand;
    f_c   = carry_in;
    unique case (1'b1)
      (amount == 8'd0): begin
        f_res = operand;
        f_c   = carry_in;
      end
      (shift_type == LSL && amount == 8'd32): begin
        f_res = '0;
        f_c   = operand[0];
      end
      (shift_type == LSR && amount == 8'd32): begin
        f_res = '0;
        f_c   = operand[31];
      end
      ((shift_type == LSL || shift_type == LSR)
        && amount > 8'd32): begin
        f_res = '0;
        f_c   = 1'b0;
      end
      (shift_type == ASR && amount >= 8'd32): begin
        f_res = {32{operand[31]}};
        f_c   = operand[31];
      end
      (shift_type == ROR && amount != 8'd0
        && amount[4:0] == 5'd0): begin
        f_res = operand;
        f_c   = operand[31];
      end
      default: fast = 1'b0;
    endcase
  end

  // step is never 0 in SHIFT, so -step mod 32 equals 32-step
  always_comb begin
    step = (rem < SM) ? rem : SM;
    nxt  = work;
    nc   = 1'b0;
    unique case (typ)
      LSL: begin
        nxt = work << step;
        nc  = work[5'd0 - step];
      end
      LSR: begin
        nxt = work >> step;
        nc  = work[step - 5'd1];
      end
      ASR: begin
        nxt = 32'($signed(work) >>> step);
        nc  = work[step - 5'd1];
      end
      default: begin
        nxt = (work >> step) | (work << (5'd0 - step));
        nc  = work[step - 5'd1];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      typ       <= LSL;
      work      <= '0;
      rem       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            typ  <= shift_type;
            work <= operand;
            if (fast) begin
              rem       <= '0;
              result    <= f_res;
              carry_out <= f_c;
              state     <= DONE;
            end else begin
              rem   <= amount[4:0];
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= nxt;
          rem  <= rem - step;
          if (rem == step) begin
            result    <= nxt;
            carry_out <= nc;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with STEP_MAX=8.
// Expected values are hand-computed constants.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  shift_type;
  logic [31:0] operand;
  logic [7:0]  amount;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int compared = 0;
  int mismatched = 0;

  shift_sequencer #(.STEP_MAX(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shift_type(shift_type),
    .operand   (operand),
    .amount    (amount),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] t,
                     input logic [31:0] op, input logic [7:0] amt,
                     input logic cin, input logic [31:0] er,
                     input logic ec, input int el);
    int lat;
    @(negedge clk);
    shift_type = t;
    operand    = op;
    amount     = amt;
    carry_in   = cin;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    operand    = 32'hDEAD_BEEF;
    amount     = 8'hAA;
    carry_in   = ~cin;
    shift_type = ~t;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(el));
    chk({tag, ".res"}, result, er);
    chk({tag, ".c"}, {31'd0, carry_out}, {31'd0, ec});
    @(negedge clk);
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    shift_type = 2'b00;
    operand = '0;
    amount = '0;
    carry_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.c", {31'd0, carry_out}, 32'd0);
    reset = 1'b0;

    run("lsl4", 2'b00, 32'h0000_00FF, 8'd4, 1'b1, 32'h0000_0FF0, 1'b0, 2);
    run("lsr32", 2'b01, 32'h8000_0001, 8'd32, 1'b0, 32'h0, 1'b1, 1);
    run("lsr40", 2'b01, 32'h8000_0001, 8'd40, 1'b1, 32'h0, 1'b0, 1);
    run("asr31", 2'b10, 32'h8000_0000, 8'd31, 1'b0, 32'hFFFF_FFFF, 1'b0, 5);
    run("asr200", 2'b10, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 1);
    run("ror36", 2'b11, 32'h0000_000F, 8'd36, 1'b0, 32'hF000_0000, 1'b1, 2);
    run("ror64", 2'b11, 32'h0000_000F, 8'd64, 1'b1, 32'h0000_000F, 1'b0, 1);
    run("z.lsl", 2'b00, 32'h1234_5678, 8'd0, 1'b1, 32'h1234_5678, 1'b1, 1);
    run("z.lsr", 2'b01, 32'h1234_5678, 8'd0, 1'b1, 32'h1234_5678, 1'b1, 1);
    run("z.asr", 2'b10, 32'h1234_5678, 8'd0, 1'b1, 32'h1234_5678, 1'b1, 1);
    run("z.ror", 2'b11, 32'h1234_5678, 8'd0, 1'b1, 32'h1234_5678, 1'b1, 1);
    run("lsl32", 2'b00, 32'h8000_0001, 8'd32, 1'b0, 32'h0, 1'b1, 1);
    run("lsl33", 2'b00, 32'h8000_0001, 8'd33, 1'b1, 32'h0, 1'b0, 1);
    run("lsl1", 2'b00, 32'h8000_0001, 8'd1, 1'b0, 32'h0000_0002, 1'b1, 2);
    run("ror12", 2'b11, 32'h1234_5678, 8'd12, 1'b1, 32'h6781_2345, 1'b0, 3);
    run("lsr20", 2'b01, 32'hF000_0000, 8'd20, 1'b1, 32'h0000_0F00, 1'b0, 4);

    // start held through SHIFT and DONE must be ignored
    @(negedge clk);
    shift_type = 2'b10;
    operand = 32'h8000_0000;
    amount = 8'd31;
    carry_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    shift_type = 2'b00;
    operand = 32'h0000_0001;
    amount = 8'd1;
    carry_in = 1'b1;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign.lat", 32'(lat), 32'd5);
    chk("ign.res", result, 32'hFFFF_FFFF);
    chk("ign.c", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("ign.idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ign.idle2", {31'd0, busy}, 32'd0);
    chk("ign.res2", result, 32'hFFFF_FFFF);

    // reset in the second SHIFT cycle aborts with no done pulse
    shift_type = 2'b10;
    operand = 32'h8000_0000;
    amount = 8'd31;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abt.busy0", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abt.busy", {31'd0, busy}, 32'd0);
    chk("abt.done", {31'd0, done}, 32'd0);
    chk("abt.res", result, 32'd0);
    chk("abt.c", {31'd0, carry_out}, 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abt.nodone", {31'd0, seen}, 32'd0);

    // reset wins over a simultaneous start
    operand = 32'h0000_0003;
    amount = 8'd0;
    carry_in = 1'b1;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("rs.busy", {31'd0, busy}, 32'd0);
    chk("rs.res", result, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for register-specified shifts (amount taken from the low byte of Rs, 0–255). It resolves the ARM special cases (amount 0, exactly 32, above 32, ROR modulo 32) in a single cycle. All other shifts are iterated in chunks of at most STEP_MAX bits per cycle, so the wide barrel network stays off the critical path. It sits beside the execute-stage operand-2 shifter and is started by the decode/control unit when an instruction uses a register shift amount.

## Interface
- STEP_MAX, default 8: maximum bits shifted per SHIFT cycle; a power of two in the range 1–16.
- clk  in  1: clock, rising edge.
- reset  in  1: synchronous, active-high.
- start  in  1: request pulse; sampled only when busy=0.
- shift_type  in  2: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- operand  in  32: Rm value.
- amount  in  8: Rs[7:0].
- carry_in  in  1: current CPSR C flag.
- busy  out  1: high whenever state is not IDLE.
- done  out  1: one-cycle pulse; result and carry_out are valid.
- result  out  32: shifted operand.
- carry_out  out  1: shifter carry out.

## Operation
- FSM states are IDLE, SHIFT, DONE.
- start with busy=0 latches shift_type, operand, amount and carry_in. Input changes while busy have no effect.
- start while busy=1 is ignored. This includes the DONE cycle.
- Fast path: IDLE goes directly to DONE, computing the result in the start cycle. Cases:
  - amount=0, any type: result=operand, carry_out=carry_in.
  - LSL, amount=32: result=0, carry_out=operand[0].
  - LSL, amount>32: result=0, carry_out=0.
  - LSR, amount=32: result=0, carry_out=operand[31].
  - LSR, amount>32: result=0, carry_out=0.
  - ASR, amount≥32: result = 32 copies of operand[31], carry_out=operand[31].
  - ROR, amount≠0 with amount[4:0]=0: result=operand, carry_out=operand[31].
- Iterative path: IDLE goes to SHIFT with a 5-bit remaining count `rem`.
  - `rem` = amount for LSL/LSR/ASR with amount 1–31.
  - `rem` = amount[4:0] for ROR.
- Each SHIFT cycle:
  - step = min(rem, STEP_MAX).
  - Shift the working register by step (logical, arithmetic or rotate, per the latched type).
  - carry_out = the last bit shifted out in this step: LSL operand bit [32−step]; LSR, ASR and ROR bit [step−1] of the working value.
  - rem = rem − step.
  - When rem reaches 0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- result and carry_out hold their values until the next accepted start completes.
- Reset values: state IDLE, busy 0, done 0, result 0x0000_0000, carry_out 0, rem 0.

## Timing
- Let start be sampled at edge E0.
- Fast path: done=1 in the cycle after E0 (latency 1); busy is high in that same cycle.
- Iterative path: N = ceil(rem/STEP_MAX) SHIFT cycles, then DONE. done is high N+1 cycles after E0.
  - STEP_MAX=8 gives a worst case of 5 cycles (rem=31).
  - STEP_MAX=1 gives a worst case of 32 cycles.
- A new start may be sampled in the first cycle busy=0 after done, so the minimum issue interval is latency+1.
- result and carry_out are registered. They change only at the edge that enters DONE, never mid-SHIFT as visible outputs: the working register is internal.
- Reset asserted mid-SHIFT or in DONE:
  - Next cycle: IDLE, busy=0, done=0, outputs cleared.
  - No done pulse is emitted for the aborted operation.
- reset and start in the same cycle: reset wins and start is dropped.

## Test plan
All scenarios use STEP_MAX=8.
- LSL, operand 0x0000_00FF, amount 4, carry_in 1 -> result 0x0000_0FF0, carry_out 0. done 2 cycles after start (1 SHIFT cycle).
- LSR, operand 0x8000_0001:
  - amount 32 -> result 0, carry_out 1, done 1 cycle after start.
  - amount 40 -> result 0, carry_out 0.
- ASR, operand 0x8000_0000:
  - amount 31 -> result 0xFFFF_FFFF, carry_out 0. Exactly 4 SHIFT cycles, done 5 cycles after start.
  - amount 200 -> result 0xFFFF_FFFF, carry_out 1, fast path.
- ROR, operand 0x0000_000F:
  - amount 36 -> result 0xF000_0000, carry_out 1.
  - amount 64 -> result 0x0000_000F, carry_out 0, fast path.
- amount 0, each of the 4 types, operand 0x1234_5678, carry_in 1 -> result 0x1234_5678, carry_out 1, done 1 cycle after start.
- Issue ASR amount 31 and assert start again with different operands during SHIFT -> second start ignored; the result is still that of the first operation.
- Issue ASR amount 31, then reset in SHIFT cycle 2 -> next cycle busy=0, result 0, carry_out 0, and no done pulse.
